// File: rtl/load_store_unit.sv
// Load/store unit: takes one LOAD or STORE from the execute stage, runs a req/ack
// handshake to data memory, and returns a one-cycle response with range and timeout checks.
module load_store_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_load,
  input  logic              cpu_store,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH);
  localparam logic [7:0]        COUNT_LAST  = 8'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [7:0]        count, count_next;
  logic              op_we, op_we_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] wdata_q, wdata_next;
  logic              rsp_err_next;
  logic [DATA_W-1:0] rsp_rdata_next;
  logic              accept;

  assign accept = cpu_valid & cpu_ready;

  always_comb begin
    state_next     = state;
    count_next     = count;
    op_we_next     = op_we;
    addr_next      = addr_q;
    wdata_next     = wdata_q;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;

    case (state)
      IDLE: begin
        count_next = '0;
        if (accept) begin
          if (cpu_load ^ cpu_store) begin
            op_we_next = cpu_store;
            addr_next  = cpu_addr;
            wdata_next = cpu_wdata;
            if (cpu_addr < DEPTH_LIMIT) begin
              state_next = REQ;
            end else begin
              state_next   = RESP;
              rsp_err_next = 1'b1;
            end
          end else if (cpu_load & cpu_store) begin
            state_next   = RESP;
            rsp_err_next = 1'b1;
          end
        end
      end

      // An ack arriving in the final allowed cycle still wins over the timeout.
      REQ: begin
        count_next = count + 8'd1;
        if (mem_ack) begin
          state_next     = RESP;
          rsp_rdata_next = op_we ? '0 : mem_rdata;
        end else if (count == COUNT_LAST) begin
          state_next   = RESP;
          rsp_err_next = 1'b1;
        end
      end

      RESP: begin
        state_next = IDLE;
        count_next = '0;
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Every output is registered off the next state, so it lines up with the state it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      op_we     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_ready <= 1'b1;
      stall     <= 1'b0;
      mem_req   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      op_we     <= op_we_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      cpu_ready <= (state_next == IDLE);
      stall     <= (state_next != IDLE);
      mem_req   <= (state_next == REQ);
      rsp_valid <= (state_next == RESP);
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  assign mem_we    = op_we;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
